// File: rtl/timer_multi.sv
// Multi-channel down-counting timer. Each channel reloads or stops on expiry
// and emits a one-cycle registered trigger pulse.
module timer_multi #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEL_W    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      valid,
  input  logic [SEL_W-1:0]          sel,
  input  logic [WIDTH-1:0]          value,
  input  logic                      mode,
  output logic [CHANNELS-1:0]       trigger,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // A select outside 0..CHANNELS-1 matches no channel, so it is ignored.
    localparam logic [SEL_W-1:0] Idx = SEL_W'(i);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             trigger_q, trigger_d;
    logic             load;

    assign load = valid && (sel == Idx);

    always_comb begin
      count_d   = count_q;
      reload_d  = reload_q;
      mode_d    = mode_q;
      trigger_d = 1'b0;
      if (load) begin
        // A load wins over an expiry in the same cycle; no trigger then.
        count_d  = value;
        reload_d = value;
        mode_d   = mode;
      end else if (enable[i]) begin
        if (count_q == One) begin
          trigger_d = 1'b1;
          count_d   = mode_q ? reload_q : '0;
        end else if (count_q != '0) begin
          count_d = count_q - One;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        count_q   <= '0;
        reload_q  <= '0;
        mode_q    <= 1'b0;
        trigger_q <= 1'b0;
      end else begin
        count_q   <= count_d;
        reload_q  <= reload_d;
        mode_q    <= mode_d;
        trigger_q <= trigger_d;
      end
    end

    assign count[i*WIDTH +: WIDTH] = count_q;
    assign trigger[i]              = trigger_q;
    assign busy[i]                 = |count_q;
  end

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi with three channels so that sel=3 is an
// out-of-range select.
module tb_timer_multi;

  localparam int unsigned W  = 5;
  localparam int unsigned CH = 3;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     enable;
  logic              valid;
  logic [SW-1:0]     sel;
  logic [W-1:0]      value;
  logic              mode;
  logic [CH-1:0]     trigger;
  logic [CH*W-1:0]   count;
  logic [CH-1:0]     busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] count0, count1, count2;
  assign count0 = count[0*W +: W];
  assign count1 = count[1*W +: W];
  assign count2 = count[2*W +: W];

  timer_multi #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .valid   (valid),
    .sel     (sel),
    .value   (value),
    .mode    (mode),
    .trigger (trigger),
    .count   (count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int v, input logic m);
    valid = 1'b1;
    sel   = SW'(ch);
    value = W'(v);
    mode  = m;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = '1;
    load(0, 9, 1'b1);
    tick();
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %h want 0", count); end
    checks++;
    if (trigger !== '0) begin errors++; $display("FAIL reset_trigger got %b want 0", trigger); end
    checks++;
    if (busy !== '0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1; valid = 1'b0; enable = '0;
    tick();
  endtask

  task automatic test_one_shot();
    enable = 3'b001;
    load(0, 5, 1'b0);
    tick();
    valid = 1'b0;
    checks++;
    if (count0 !== 5 || trigger[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL oneshot_load count0 %0d trig %b busy %b want 5 0 1",
                         count0, trigger[0], busy[0]);
    end
    for (int k = 4; k >= 0; k--) begin
      tick();
      checks++;
      if (count0 !== W'(k) || trigger[0] !== (k == 0)) begin
        errors++; $display("FAIL oneshot_run count0 %0d trig %b want %0d %b",
                           count0, trigger[0], k, (k == 0));
      end
    end
    tick();
    checks++;
    if (count0 !== 0 || trigger[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL oneshot_idle count0 %0d trig %b busy %b want 0 0 0",
                         count0, trigger[0], busy[0]);
    end
  endtask

  task automatic test_periodic();
    int exp;
    enable = 3'b010;
    load(1, 3, 1'b1);
    tick();
    valid = 1'b0;
    checks++;
    if (count1 !== 3 || trigger[1] !== 1'b0) begin
      errors++; $display("FAIL periodic_load count1 %0d trig %b want 3 0", count1, trigger[1]);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = (k % 3 == 0) ? 3 : 3 - (k % 3);
      checks++;
      if (count1 !== W'(exp) || trigger[1] !== (k % 3 == 0) || count0 !== 0) begin
        errors++; $display("FAIL periodic_run k=%0d count1 %0d trig %b count0 %0d want %0d %b 0",
                           k, count1, trigger[1], count0, exp, (k % 3 == 0));
      end
    end
  endtask

  task automatic test_pause();
    enable = 3'b001;
    load(0, 10, 1'b0);
    tick();
    valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (count0 !== 6) begin errors++; $display("FAIL pause_pre count0 %0d want 6", count0); end
    enable = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (count0 !== 6 || trigger[0] !== 1'b0) begin
        errors++; $display("FAIL pause_hold count0 %0d trig %b want 6 0", count0, trigger[0]);
      end
    end
    enable = 3'b001;
    for (int k = 5; k >= 0; k--) begin
      tick();
      checks++;
      if (count0 !== W'(k) || trigger[0] !== (k == 0)) begin
        errors++; $display("FAIL pause_resume count0 %0d trig %b want %0d %b",
                           count0, trigger[0], k, (k == 0));
      end
    end
  endtask

  task automatic test_collision();
    enable = 3'b010;
    load(1, 2, 1'b1);
    tick();
    valid = 1'b0;
    tick();
    checks++;
    if (count1 !== 1) begin errors++; $display("FAIL collide_pre count1 %0d want 1", count1); end
    load(1, 7, 1'b0);
    tick();
    valid = 1'b0;
    checks++;
    if (count1 !== 7 || trigger[1] !== 1'b0) begin
      errors++; $display("FAIL collide count1 %0d trig %b want 7 0", count1, trigger[1]);
    end
    enable = 3'b000;
    load(0, 12, 1'b0);
    tick();
    load(3, 9, 1'b1);
    tick();
    valid = 1'b0;
    checks++;
    if (count !== {5'd0, 5'd7, 5'd12} || trigger !== '0) begin
      errors++; $display("FAIL bad_sel count %h trig %b want %h 0",
                         count, trigger, {5'd0, 5'd7, 5'd12});
    end
    enable = 3'b011;
    tick();
    checks++;
    if (count0 !== 11 || count1 !== 6 || count2 !== 0) begin
      errors++; $display("FAIL bad_sel_run counts %0d %0d %0d want 11 6 0",
                         count0, count1, count2);
    end
  endtask

  task automatic test_reset_mid();
    enable = 3'b000;
    load(0, 4, 1'b1);
    tick();
    load(1, 2, 1'b1);
    tick();
    valid = 1'b0;
    enable = 3'b011;
    reset = 1'b0;
    tick();
    checks++;
    if (count !== '0 || trigger !== '0 || busy !== '0) begin
      errors++; $display("FAIL reset_mid count %h trig %b busy %b want 0 0 0",
                         count, trigger, busy);
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (count !== '0 || trigger !== '0 || busy !== '0) begin
        errors++; $display("FAIL reset_idle count %h trig %b busy %b want 0 0 0",
                           count, trigger, busy);
      end
    end
  endtask

  task automatic test_boundary();
    enable = 3'b001;
    load(0, 0, 1'b1);
    tick();
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (count0 !== 0 || busy[0] !== 1'b0 || trigger[0] !== 1'b0) begin
        errors++; $display("FAIL zero_load count0 %0d busy %b trig %b want 0 0 0",
                           count0, busy[0], trigger[0]);
      end
    end
    load(0, 31, 1'b0);
    tick();
    valid = 1'b0;
    checks++;
    if (count0 !== 31 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL max_load count0 %0d busy %b want 31 1", count0, busy[0]);
    end
    for (int k = 1; k <= 31; k++) begin
      tick();
      checks++;
      if (count0 !== W'(31 - k) || trigger[0] !== (k == 31)) begin
        errors++; $display("FAIL max_run k=%0d count0 %0d trig %b want %0d %b",
                           k, count0, trigger[0], 31 - k, (k == 31));
      end
    end
    tick();
    checks++;
    if (count0 !== 0 || trigger[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL max_after count0 %0d trig %b busy %b want 0 0 0",
                         count0, trigger[0], busy[0]);
    end
  endtask

  initial begin
    reset = 1'b0; enable = '0; valid = 1'b0; sel = '0; value = '0; mode = 1'b0;
    tick();
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause();
    test_collision();
    test_reset_mid();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
